// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time on the
// req/addr_ok/data_ok port and presents PC/instruction/valid to IC/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        STALL,
    input  logic              BR_FLAG,
    input  logic [ADDR_W-1:0] BR_ADDR,
    output logic              INST_REQ,
    output logic [ADDR_W-1:0] INST_ADDR,
    input  logic              INST_ADDR_OK,
    input  logic              INST_DATA_OK,
    input  logic [DATA_W-1:0] INST_RDATA,
    output logic [ADDR_W-1:0] IC_PC,
    output logic [DATA_W-1:0] IC_INST,
    output logic              IV,
    output logic              IF_STALL_REQ
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx, target;
    logic [DATA_W-1:0]  hold_buf, hand_data;
    logic               kill, redir_pend, handoff;
    logic               unused_stall;

    assign unused_stall = STALL[1];

    always_comb begin
        state_nx     = state;
        handoff      = 1'b0;
        hand_data    = INST_RDATA;
        INST_REQ     = 1'b0;
        IF_STALL_REQ = 1'b0;
        case (state)
            S_REQ: begin
                INST_REQ     = 1'b1;
                IF_STALL_REQ = 1'b1;
                if (INST_ADDR_OK) state_nx = S_WAIT;
            end
            S_WAIT: begin
                IF_STALL_REQ = ~INST_DATA_OK;
                if (INST_DATA_OK) begin
                    if (!STALL[0]) begin
                        handoff  = 1'b1;
                        state_nx = S_REQ;
                    end else begin
                        state_nx = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                hand_data = hold_buf;
                if (!STALL[0]) begin
                    handoff  = 1'b1;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    // A branch seen in the hand-off cycle redirects directly; otherwise the
    // latched target is used once the in-flight fetch drains.
    always_comb begin
        pc_nx = pc + ADDR_W'(4);
        if (BR_FLAG)         pc_nx = BR_ADDR;
        else if (redir_pend) pc_nx = target;
    end

    assign INST_ADDR = pc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_REQ;
            pc         <= RESET_PC[ADDR_W-1:0];
            kill       <= 1'b0;
            redir_pend <= 1'b0;
            target     <= '0;
            hold_buf   <= '0;
            IC_PC      <= '0;
            IC_INST    <= '0;
            IV         <= 1'b0;
        end else begin
            state <= state_nx;
            if (handoff) begin
                IC_PC      <= pc;
                IC_INST    <= hand_data;
                IV         <= ~(kill | BR_FLAG);
                pc         <= pc_nx;
                kill       <= 1'b0;
                redir_pend <= 1'b0;
            end else if (BR_FLAG) begin
                kill       <= 1'b1;
                redir_pend <= 1'b1;
                target     <= BR_ADDR;
            end
            if (state == S_WAIT && INST_DATA_OK && STALL[0])
                hold_buf <= INST_RDATA;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a cycle table for the sequential/stall/branch
// flow, plus hand-written sequences for hand-off branches, reset and wrap.
module tb_if_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  STALL;
    logic        BR_FLAG;
    logic [31:0] BR_ADDR;
    logic        INST_REQ;
    logic [31:0] INST_ADDR;
    logic        INST_ADDR_OK;
    logic        INST_DATA_OK;
    logic [31:0] INST_RDATA;
    logic [31:0] IC_PC;
    logic [31:0] IC_INST;
    logic        IV;
    logic        IF_STALL_REQ;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    if_fetch dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .BR_FLAG(BR_FLAG), .BR_ADDR(BR_ADDR),
        .INST_REQ(INST_REQ), .INST_ADDR(INST_ADDR), .INST_ADDR_OK(INST_ADDR_OK),
        .INST_DATA_OK(INST_DATA_OK), .INST_RDATA(INST_RDATA), .IC_PC(IC_PC),
        .IC_INST(IC_INST), .IV(IV), .IF_STALL_REQ(IF_STALL_REQ)
    );

    // Inputs applied for one cycle; expected outputs seen during that cycle
    // (registered outputs reflect the edges before it).
    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bra;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sreq;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_iv;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic br,
                         input logic [31:0] bra, input logic aok, input logic dok,
                         input logic [31:0] rdata);
        @(negedge CLK);
        RST = rst; STALL = {1'b0, stall}; BR_FLAG = br; BR_ADDR = bra;
        INST_ADDR_OK = aok; INST_DATA_OK = dok; INST_RDATA = rdata;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        //            stl br bra           aok dok rdata          req addr          sreq pc            inst          iv
        vecs[0]  = '{0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hBFC00000, 1, 32'h0,        32'h0,        0};
        vecs[1]  = '{0, 0, 32'h0,         0, 1, 32'hAED11111,  0, 32'hBFC00000, 0, 32'h0,        32'h0,        0};
        vecs[2]  = '{0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hBFC00004, 1, 32'hBFC00000, 32'hAED11111, 1};
        vecs[3]  = '{1, 0, 32'h0,         0, 1, 32'hAED11115,  0, 32'hBFC00004, 0, 32'hBFC00000, 32'hAED11111, 1};
        vecs[4]  = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'hBFC00004, 0, 32'hBFC00000, 32'hAED11111, 1};
        vecs[5]  = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'hBFC00004, 0, 32'hBFC00000, 32'hAED11111, 1};
        vecs[6]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 32'hBFC00004, 0, 32'hBFC00000, 32'hAED11111, 1};
        vecs[7]  = '{0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hBFC00008, 1, 32'hBFC00004, 32'hAED11115, 1};
        vecs[8]  = '{0, 1, 32'hBFC00100,  0, 0, 32'h0,         0, 32'hBFC00008, 1, 32'hBFC00004, 32'hAED11115, 1};
        vecs[9]  = '{0, 0, 32'h0,         0, 1, 32'hAED11119,  0, 32'hBFC00008, 0, 32'hBFC00004, 32'hAED11115, 1};
        vecs[10] = '{0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hBFC00100, 1, 32'hBFC00008, 32'hAED11119, 0};
        vecs[11] = '{0, 0, 32'h0,         0, 1, 32'hAED11011,  0, 32'hBFC00100, 0, 32'hBFC00008, 32'hAED11119, 0};
        vecs[12] = '{0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hBFC00104, 1, 32'hBFC00100, 32'hAED11011, 1};

        do_reset();
        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].stall, vecs[i].br, vecs[i].bra, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            chk($sformatf("v%0d req", i),  {31'b0, INST_REQ},     {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d addr", i), INST_ADDR,             vecs[i].e_addr);
            chk($sformatf("v%0d sreq", i), {31'b0, IF_STALL_REQ}, {31'b0, vecs[i].e_sreq});
            chk($sformatf("v%0d ic_pc", i), IC_PC,                vecs[i].e_pc);
            chk($sformatf("v%0d ic_inst", i), IC_INST,            vecs[i].e_inst);
            chk($sformatf("v%0d iv", i),   {31'b0, IV},           {31'b0, vecs[i].e_iv});
        end

        // Branch coinciding with the data_ok of BFC00008
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("hb addr8", INST_ADDR, 32'hBFC00008);
        drive(1'b0, 1'b0, 1'b1, 32'hBFC00100, 1'b0, 1'b1, 32'h3);
        idle();
        chk("hb ic_pc", IC_PC, 32'hBFC00008);
        chk("hb iv", {31'b0, IV}, 32'h0);
        chk("hb req", {31'b0, INST_REQ}, 32'h1);
        chk("hb addr", INST_ADDR, 32'hBFC00100);

        // Back-to-back branches while addr_ok is held off
        drive(1'b0, 1'b0, 1'b1, 32'h00000200, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h00000300, 1'b0, 1'b0, 32'h0);
        chk("bb addr stable1", INST_ADDR, 32'hBFC00100);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("bb addr stable2", INST_ADDR, 32'hBFC00100);
        chk("bb req held", {31'b0, INST_REQ}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        idle();
        chk("bb ic_pc", IC_PC, 32'hBFC00100);
        chk("bb ic_inst", IC_INST, 32'hDEADBEEF);
        chk("bb iv", {31'b0, IV}, 32'h0);
        chk("bb next addr", INST_ADDR, 32'h00000300);

        // Reset while waiting for data, then a stale data_ok
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678);
        chk("rst ic_pc", IC_PC, 32'h0);
        chk("rst ic_inst", IC_INST, 32'h0);
        chk("rst iv", {31'b0, IV}, 32'h0);
        chk("rst addr", INST_ADDR, 32'hBFC00000);
        idle();
        chk("late dok req", {31'b0, INST_REQ}, 32'h1);
        chk("late dok ic_pc", IC_PC, 32'h0);
        chk("late dok iv", {31'b0, IV}, 32'h0);

        // Branch to FFFFFFFC and let the PC wrap
        drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap killed iv", {31'b0, IV}, 32'h0);
        chk("wrap addr top", INST_ADDR, 32'hFFFFFFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
        idle();
        chk("wrap ic_pc", IC_PC, 32'hFFFFFFFC);
        chk("wrap ic_inst", IC_INST, 32'hCAFEF00D);
        chk("wrap iv", {31'b0, IV}, 32'h1);
        chk("wrap addr zero", INST_ADDR, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
